// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the encrypt core.
// Optional AES_LAST_KEY output is enabled by macro AES_ENC_LASTKEY_EN.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  localparam logic [3:0] NR = 4'd10;

  // Rcon[1] in the top byte down to Rcon[10] in the bottom byte
  localparam logic [79:0] RCON_TAB = 80'h01020408102040801b36;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = '0;
    if (r >= 4'd1 && r <= NR)
      v = RCON_TAB[8*(NR-r) +: 8];
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box.
// Optional AES_LAST_KEY output is enabled by macro AES_ENC_LASTKEY_EN.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so index with the inverted input
  localparam logic [2047:0] TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = TAB[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encrypt core, one round per cycle, on-the-fly key schedule.
// Optional AES_LAST_KEY output is enabled by macro AES_ENC_LASTKEY_EN.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_DEC,
  output logic [127:0] AES_MSG_ENC,
`ifdef AES_ENC_LASTKEY_EN
  output logic [127:0] AES_LAST_KEY,
`endif
  output logic         AES_DONE
);

  aes_state_e   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] enc_q, enc_d;
  logic         done_q, done_d;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] lkey_q, lkey_d;
`endif

  logic [127:0] sb_st;
  logic [127:0] sr_st;
  logic [127:0] mc_st;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [127:0] nkey;

  for (genvar i = 0; i < 16; i++) begin : g_sb_st
    aes_sbox u_sbox (
      .din  (st_q[127-8*i -: 8]),
      .dout (sb_st[127-8*i -: 8])
    );
  end

  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb_key
    aes_sbox u_sbox (
      .din  (rot_w[31-8*i -: 8]),
      .dout (sub_w[31-8*i -: 8])
    );
  end

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  // Byte (r,c) lives at index 4c+r; row r rotates left by r columns
  always_comb begin
    sr_st = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_st[127-8*(4*c+r) -: 8] =
          sb_st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mc_st = '0;
    for (int c = 0; c < 4; c++) begin
      mc_st[127-32*c -: 32] = mix_col(sr_st[127-32*c -: 32]);
    end
  end

  always_comb begin
    logic [31:0] t;
    t = sub_w ^ {rcon(rnd_q), 24'h0};
    nkey[127:96] = key_q[127:96] ^ t;
    nkey[95:64]  = key_q[95:64] ^ nkey[127:96];
    nkey[63:32]  = key_q[63:32] ^ nkey[95:64];
    nkey[31:0]   = key_q[31:0] ^ nkey[63:32];
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    enc_d   = enc_q;
    done_d  = 1'b0;
`ifdef AES_ENC_LASTKEY_EN
    lkey_d  = lkey_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (AES_START) begin
          key_d   = AES_KEY;
          st_d    = AES_MSG_DEC;
          state_d = INIT;
        end
      end
      INIT: begin
        st_d    = st_q ^ key_q;
        rnd_d   = 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        st_d  = mc_st ^ nkey;
        key_d = nkey;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == NR - 4'd1)
          state_d = FINAL;
      end
      FINAL: begin
        enc_d   = sr_st ^ nkey;
        key_d   = nkey;
`ifdef AES_ENC_LASTKEY_EN
        lkey_d  = nkey;
`endif
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (AES_START) begin
          done_d = 1'b1;
        end else begin
          rnd_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
`ifdef AES_ENC_LASTKEY_EN
      lkey_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
`ifdef AES_ENC_LASTKEY_EN
      lkey_q  <= lkey_d;
`endif
    end
  end

  assign AES_MSG_ENC  = enc_q;
  assign AES_DONE     = done_q;
`ifdef AES_ENC_LASTKEY_EN
  assign AES_LAST_KEY = lkey_q;
`endif

endmodule

// File: tb/tb_aes_encrypt.sv
// Randomised scoreboard bench for aes_encrypt against a textbook AES-128 model.
// Checks AES_LAST_KEY as well when built with AES_ENC_LASTKEY_EN.
module tb_aes_encrypt;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] msg;
  logic [127:0] enc;
  logic         done;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] lkey;
`endif

  aes_encrypt dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .AES_START    (start),
    .AES_KEY      (key),
    .AES_MSG_DEC  (msg),
    .AES_MSG_ENC  (enc),
`ifdef AES_ENC_LASTKEY_EN
    .AES_LAST_KEY (lkey),
`endif
    .AES_DONE     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] enc;
    logic [127:0] lk;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;
  logic [7:0] tsb [256];

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_M = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_M  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_LK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
             ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic exp_t ref_enc(input logic [127:0] k, input logic [127:0] m);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    exp_t        r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {tsb[tmp[31:24]], tsb[tmp[23:16]], tsb[tmp[15:8]], tsb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = m[127-8*i -: 8];
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = tsb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          if (rnd < 10)
            s[4*c+rr] = gmul(8'h02, t[4*c+rr]) ^ gmul(8'h03, t[4*c+(rr+1)%4])
                      ^ t[4*c+(rr+2)%4] ^ t[4*c+(rr+3)%4];
          else
            s[4*c+rr] = t[4*c+rr];
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r.enc[127-8*i -: 8] = s[i];
    r.lk = {w[40], w[41], w[42], w[43]};
    return r;
  endfunction

  // Monitor: one scoreboard pop per rising AES_DONE
  logic done_d1 = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d1) begin
      if (sbq.size() == 0) begin
        chk_int("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ciphertext", enc, e.enc);
`ifdef AES_ENC_LASTKEY_EN
        chk("last_key", lkey, e.lk);
`endif
      end
    end
    done_d1 = done;
  end

  // hold: edges with AES_START high; corrupt: disturb inputs mid-run
  task automatic run(input logic [127:0] k, input logic [127:0] m,
                     input exp_t e, input int hold, input bit corrupt,
                     input bit pre);
    int first, last, last_exp;
    first = -1;
    last = -1;
    last_exp = (hold - 1 > 11) ? hold - 1 : 11;
    if (!pre) begin
      @(negedge clk);
      key = k;
      msg = m;
      start = 1'b1;
    end
    sbq.push_back(e);
    for (int ed = 0; ed < 40; ed++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first < 0) first = ed;
        last = ed;
      end
      if (ed == hold - 1) start = 1'b0;
      if (corrupt && ed == 2) begin
        msg = '1;
        key = ~key;
        start = 1'b1;
      end
      if (corrupt && ed == 4) start = 1'b0;
      if (first >= 0 && !done) break;
    end
    chk_int("done_latency", first, 11);
    chk_int("done_last_edge", last, last_exp);
  endtask

  task automatic run_model(input logic [127:0] k, input logic [127:0] m,
                           input int hold);
    run(k, m, ref_enc(k, m), hold, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    msg = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", {127'h0, done}, '0);
    chk("reset_enc", enc, '0);
    rst_n = 1'b1;

    e = ref_enc(C1_K, C1_M);
    e.enc = C1_C;
    run(C1_K, C1_M, e, 1, 1'b0, 1'b0);

    e.enc = B_C;
    e.lk = B_LK;
    run(B_K, B_M, e, 20, 1'b0, 1'b0);

    e = ref_enc(C1_K, C1_M);
    e.enc = C1_C;
    run(C1_K, C1_M, e, 1, 1'b1, 1'b0);

    run(C1_K, C1_M, e, 1, 1'b0, 1'b0);
    e.enc = B_C;
    e.lk = B_LK;
    run(B_K, B_M, e, 1, 1'b0, 1'b0);

    @(negedge clk);
    key = C1_K;
    msg = C1_M;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_done", {127'h0, done}, '0);
    chk("abort_enc", enc, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = ref_enc(C1_K, C1_M);
    e.enc = C1_C;
    run(C1_K, C1_M, e, 1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [127:0] rk, rm;
      rk = {$urandom, $urandom, $urandom, $urandom};
      rm = {$urandom, $urandom, $urandom, $urandom};
      run_model(rk, rm, int'($urandom_range(1, 20)));
    end

    repeat (3) @(negedge clk);
    chk_int("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port: RESET_N  in  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have port: AES_START  in  1  request level; sampled high in IDLE to begin an encryption.
REQ-004 SHALL have port: AES_KEY  in  128  cipher key; bits [127:120] are key byte 0.
REQ-005 SHALL have port: AES_MSG_DEC  in  128  plaintext block; bits [127:120] are state byte 0, column-major.
REQ-006 SHALL have port: AES_MSG_ENC  out  128  ciphertext block, same byte ordering.
REQ-007 SHALL have port: AES_DONE  out  1  ciphertext valid / operation complete.
REQ-008 SHALL fix the algorithm at AES-128 encryption (Nk=4, Nr=10) with no parameters.

Function
REQ-009 SHALL implement states IDLE, INIT, ROUND, FINAL, DONE.
REQ-010 SHALL, in IDLE on an edge with AES_START=1, latch AES_KEY and AES_MSG_DEC into internal registers and go to INIT.
REQ-011 SHALL, in INIT, apply AddRoundKey with the cipher key, set round counter to 1, and go to ROUND.
REQ-012 SHALL, in ROUND, apply SubBytes, ShiftRows, MixColumns and AddRoundKey in one cycle, deriving round key r from round key r-1 on the fly (RotWord, SubWord, Rcon[r]).
REQ-013 SHALL increment the round counter each ROUND cycle and go to FINAL after round 9.
REQ-014 SHALL, in FINAL, apply SubBytes, ShiftRows and AddRoundKey (no MixColumns) with round key 10, register the result to AES_MSG_ENC, and go to DONE.
REQ-015 SHALL assert AES_DONE registered, exactly 11 rising edges after the edge that sampled AES_START in IDLE.
REQ-016 SHALL hold AES_DONE high in DONE while AES_START=1 and return to IDLE on the first edge with AES_START=0; if AES_START is already low, AES_DONE is high for exactly one cycle.
REQ-017 SHALL ignore changes of AES_KEY, AES_MSG_DEC and AES_START between the start edge and DONE.
REQ-018 SHALL hold AES_MSG_ENC stable from DONE until the next FINAL completes.
REQ-019 SHALL compute the Rcon sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-020 SHALL use GF(2^8) multiply-by-2 reduction by 0x1b in MixColumns.

Reset
REQ-021 SHALL, on RESET_N low, asynchronously force IDLE, round counter 0, AES_DONE=0, AES_MSG_ENC=0 and clear internal state/key registers.
REQ-022 SHALL abort any encryption in progress when reset is applied; no partial result appears on AES_MSG_ENC.
REQ-023 SHALL, after RESET_N deasserts with AES_START held high, start a new encryption on the first rising edge.

Configuration
REQ-024 SHALL, with macro AES_ENC_LASTKEY_EN defined, add output AES_LAST_KEY  out  128  round-10 key, registered with AES_MSG_ENC, reset to 0, valid while AES_DONE=1, supplying the decrypt core's starting key.
REQ-025 SHALL, without AES_ENC_LASTKEY_EN, omit AES_LAST_KEY; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enum, the Rcon table, the Nr=10 constant and the xtime function in shared package aes_pkg.
REQ-027 SHALL use sub-module aes_sbox (8-bit in, 8-bit out, combinational forward S-box), instantiated 16 times for the state and 4 times for key expansion.

Verification
REQ-028 SHALL cover FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> AES_MSG_ENC 69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE 11 edges after start.
REQ-029 SHALL cover FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; with AES_ENC_LASTKEY_EN, AES_LAST_KEY d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 SHALL cover the handshake: AES_START held high 20 cycles -> AES_DONE high from edge 11 until one edge after AES_START falls; a one-cycle AES_START pulse -> AES_DONE high for exactly one cycle.
REQ-031 SHALL cover input change: AES_MSG_DEC changed to all-ones at cycle 3 -> result still 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 SHALL cover reset mid-operation: RESET_N low at cycle 5 -> AES_DONE=0, AES_MSG_ENC=0 immediately; a restart yields the correct ciphertext.
REQ-033 SHALL cover back-to-back operation: two encryptions (C.1 then B vectors) separated by one AES_START-low cycle -> both ciphertexts correct.
